// File: rtl/obi_fifo_mailbox_pkg.sv
// Shared definitions for the OBI FIFO mailbox: reader register map, STATUS/CTRL
// bit layout and the register-select decode helper.
package obi_fifo_mailbox_pkg;

  // Reader-side register offsets within one queue's 16-byte window.
  localparam logic [3:0] RegOffData   = 4'h0;
  localparam logic [3:0] RegOffStatus = 4'h4;
  localparam logic [3:0] RegOffThresh = 4'h8;
  localparam logic [3:0] RegOffCtrl   = 4'hC;

  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegThresh = 2'd2,
    RegCtrl   = 2'd3
  } reg_sel_e;

  localparam int unsigned StatusLevelLsb   = 0;
  localparam int unsigned StatusLevelWidth = 16;
  localparam int unsigned StatusEmptyBit   = 16;
  localparam int unsigned StatusFullBit    = 17;
  localparam int unsigned StatusOvfBit     = 18;
  localparam int unsigned StatusUdfBit     = 19;
  localparam int unsigned StatusIrqBit     = 20;

  localparam int unsigned CtrlFlushBit = 0;
  localparam int unsigned CtrlClearBit = 1;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic [10:0] rsvd;
    logic        irq;
    logic        udf;
    logic        ovf;
    logic        full;
    logic        empty;
    logic [15:0] level;
  } status_t;

  function automatic reg_sel_e reg_sel(input logic [3:0] offset);
    return reg_sel_e'(offset[3:2]);
  endfunction

endpackage

// File: rtl/obi_fifo_mailbox_queue.sv
// Single-clock FIFO used once per mailbox queue. Flush has priority over push/pop;
// full/empty are decoded from the registered level only.
module obi_fifo_mailbox_queue #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 8,
  parameter int unsigned LevelWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [DataWidth-1:0]  wdata_i,
  output logic [DataWidth-1:0]  rdata_o,
  output logic [LevelWidth-1:0] level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [LevelWidth-1:0] r_level;
  logic [DataWidth-1:0]  r_mem [Depth];

  logic w_push;
  logic w_pop;

  assign full_o  = (r_level == LevelWidth'(Depth));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign rdata_o = r_mem[r_rd_ptr];

  assign w_push = push_i && !full_o && !flush_i;
  assign w_pop  = pop_i && !empty_o && !flush_i;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + LevelWidth'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LevelWidth'(1);
      end
    end
  end

  // NOTE: storage has no reset; the level gates every read, so stale words are never visible.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/obi_fifo_mailbox.sv
// Multi-queue OBI mailbox: writer pushes into an address-selected FIFO, reader pops
// and accesses per-queue STATUS/THRESH/CTRL; threshold irq and sticky ovf/udf flags.
module obi_fifo_mailbox
  import obi_fifo_mailbox_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned Depth       = 8,
  parameter int unsigned NumQueues   = 2,
  parameter bit          BlockOnFull = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   writer_req_i,
  output logic                   writer_gnt_o,
  input  logic [AddrWidth-1:0]   writer_addr_i,
  input  logic                   writer_we_i,
  input  logic [DataWidth/8-1:0] writer_be_i,
  input  logic [DataWidth-1:0]   writer_wdata_i,
  output logic                   writer_rvalid_o,
  output logic [DataWidth-1:0]   writer_rdata_o,
  input  logic                   reader_req_i,
  output logic                   reader_gnt_o,
  input  logic [AddrWidth-1:0]   reader_addr_i,
  input  logic                   reader_we_i,
  input  logic [DataWidth/8-1:0] reader_be_i,
  input  logic [DataWidth-1:0]   reader_wdata_i,
  output logic                   reader_rvalid_o,
  output logic [DataWidth-1:0]   reader_rdata_o,
  output logic [NumQueues-1:0]   irq_o
);

  localparam int unsigned QB = (NumQueues > 1) ? $clog2(NumQueues) : 1;
  localparam int unsigned LW = $clog2(Depth + 1);

  // Per-queue FIFO interface
  logic [NumQueues-1:0] w_push;
  logic [NumQueues-1:0] w_pop;
  logic [NumQueues-1:0] w_flush;
  logic [NumQueues-1:0] w_full;
  logic [NumQueues-1:0] w_empty;
  logic [DataWidth-1:0] w_head  [NumQueues];
  logic [LW-1:0]        w_level [NumQueues];

  // Per-queue register side effects
  logic [NumQueues-1:0] w_ovf_set;
  logic [NumQueues-1:0] w_udf_set;
  logic [NumQueues-1:0] w_flag_clr;
  logic [NumQueues-1:0] w_thresh_we;

  logic [QB-1:0]        w_wr_q;
  logic [QB-1:0]        w_rd_q;
  reg_sel_e             w_rd_sel;
  logic                 w_wr_full;
  logic                 w_wr_fire;
  logic                 w_rd_read;
  logic                 w_rd_write;
  logic [DataWidth-1:0] w_rd_rdata;

  logic [LW-1:0]        r_thresh [NumQueues];
  logic [NumQueues-1:0] r_ovf;
  logic [NumQueues-1:0] r_udf;
  logic [NumQueues-1:0] r_irq;
  logic                 r_wr_rvalid;
  logic                 r_rd_rvalid;
  logic [DataWidth-1:0] r_rd_rdata;

  // Byte enables and address bits outside the decode are intentionally don't-care.
  logic w_unused_bits;
  assign w_unused_bits = ^{writer_be_i, reader_be_i, writer_addr_i, reader_addr_i, reader_wdata_i};

  assign w_wr_q   = writer_addr_i[QB+1:2];
  assign w_rd_q   = reader_addr_i[QB+3:4];
  assign w_rd_sel = reg_sel(reader_addr_i[3:0]);

  // A queue index >= NumQueues matches no queue, so it reads as not-full and is granted.
  always_comb begin
    w_wr_full = 1'b0;
    for (int q = 0; q < NumQueues; q++) begin
      if (w_wr_q == QB'(q)) w_wr_full = w_full[q];
    end
  end

  assign writer_gnt_o    = !(BlockOnFull && writer_we_i && w_wr_full);
  assign w_wr_fire       = writer_req_i && writer_gnt_o && writer_we_i;
  assign w_rd_read       = reader_req_i && !reader_we_i;
  assign w_rd_write      = reader_req_i && reader_we_i;
  assign reader_gnt_o    = 1'b1;
  assign writer_rvalid_o = r_wr_rvalid;
  assign writer_rdata_o  = '0;
  assign reader_rvalid_o = r_rd_rvalid;
  assign reader_rdata_o  = r_rd_rdata;
  assign irq_o           = r_irq;

  // NOTE: every output of this block gets a default before the loop, so no latches form.
  always_comb begin
    status_t v_status;
    logic    v_wr_hit;
    logic    v_rd_hit;
    w_push      = '0;
    w_pop       = '0;
    w_flush     = '0;
    w_ovf_set   = '0;
    w_udf_set   = '0;
    w_flag_clr  = '0;
    w_thresh_we = '0;
    w_rd_rdata  = '0;
    v_status    = '0;
    v_wr_hit    = 1'b0;
    v_rd_hit    = 1'b0;
    for (int q = 0; q < NumQueues; q++) begin
      v_wr_hit = (w_wr_q == QB'(q));
      v_rd_hit = (w_rd_q == QB'(q));

      w_push[q]    = w_wr_fire && v_wr_hit && !w_full[q];
      w_ovf_set[q] = w_wr_fire && v_wr_hit && w_full[q];

      w_pop[q]     = w_rd_read && v_rd_hit && (w_rd_sel == RegData) && !w_empty[q];
      w_udf_set[q] = w_rd_read && v_rd_hit && (w_rd_sel == RegData) && w_empty[q];

      w_flush[q]     = w_rd_write && v_rd_hit && (w_rd_sel == RegCtrl) && reader_wdata_i[CtrlFlushBit];
      w_flag_clr[q]  = w_rd_write && v_rd_hit && (w_rd_sel == RegCtrl) && reader_wdata_i[CtrlClearBit];
      w_thresh_we[q] = w_rd_write && v_rd_hit && (w_rd_sel == RegThresh);

      if (w_rd_read && v_rd_hit) begin
        v_status       = '0;
        v_status.level = 16'(w_level[q]);
        v_status.empty = w_empty[q];
        v_status.full  = w_full[q];
        v_status.ovf   = r_ovf[q];
        v_status.udf   = r_udf[q];
        v_status.irq   = r_irq[q];
        unique case (w_rd_sel)
          RegData:   w_rd_rdata = w_empty[q] ? '0 : w_head[q];
          RegStatus: w_rd_rdata = DataWidth'(v_status);
          RegThresh: w_rd_rdata = DataWidth'(r_thresh[q]);
          default:   w_rd_rdata = '0;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NumQueues; g++) begin : g_queue
    obi_fifo_mailbox_queue #(
      .DataWidth (DataWidth),
      .Depth     (Depth),
      .LevelWidth(LW)
    ) u_queue (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (w_push[g]),
      .pop_i  (w_pop[g]),
      .flush_i(w_flush[g]),
      .wdata_i(writer_wdata_i),
      .rdata_o(w_head[g]),
      .level_o(w_level[g]),
      .full_o (w_full[g]),
      .empty_o(w_empty[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf       <= '0;
      r_udf       <= '0;
      r_irq       <= '0;
      r_wr_rvalid <= 1'b0;
      r_rd_rvalid <= 1'b0;
      r_rd_rdata  <= '0;
      for (int q = 0; q < NumQueues; q++) r_thresh[q] <= '0;
    end else begin
      r_wr_rvalid <= writer_req_i && writer_gnt_o;
      r_rd_rvalid <= reader_req_i;
      r_rd_rdata  <= w_rd_rdata;
      for (int q = 0; q < NumQueues; q++) begin
        if (w_thresh_we[q]) r_thresh[q] <= reader_wdata_i[LW-1:0];
        // A new event in the same cycle as a clear keeps the flag set.
        if (w_ovf_set[q])       r_ovf[q] <= 1'b1;
        else if (w_flag_clr[q]) r_ovf[q] <= 1'b0;
        if (w_udf_set[q])       r_udf[q] <= 1'b1;
        else if (w_flag_clr[q]) r_udf[q] <= 1'b0;
        r_irq[q] <= (r_thresh[q] != '0) && (w_level[q] >= r_thresh[q]);
      end
    end
  end

endmodule

// File: tb/tb_obi_fifo_mailbox.sv
// Bench for obi_fifo_mailbox: a blocking instance and a dropping instance share one
// stimulus; reader responses are checked against a scoreboard of expected words.
module tb_obi_fifo_mailbox;
  import obi_fifo_mailbox_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        w_req, w_we, r_req, r_we;
  logic [31:0] w_addr, w_wdata, r_addr, r_wdata;
  logic [3:0]  w_be, r_be;

  logic        d_w_gnt, d_w_rvalid, d_r_gnt, d_r_rvalid;
  logic [31:0] d_w_rdata, d_r_rdata;
  logic [1:0]  d_irq;
  logic        x_w_gnt, x_w_rvalid, x_r_gnt, x_r_rvalid;
  logic [31:0] x_w_rdata, x_r_rdata;
  logic [1:0]  x_irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] exp2;
  } sb_t;
  sb_t sb[$];

  typedef enum logic [1:0] {V_PUSH, V_READ, V_WRITE} vkind_e;
  typedef struct {
    vkind_e      kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  obi_fifo_mailbox #(.Depth(8), .NumQueues(2), .BlockOnFull(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .writer_req_i(w_req), .writer_gnt_o(d_w_gnt), .writer_addr_i(w_addr),
    .writer_we_i(w_we), .writer_be_i(w_be), .writer_wdata_i(w_wdata),
    .writer_rvalid_o(d_w_rvalid), .writer_rdata_o(d_w_rdata),
    .reader_req_i(r_req), .reader_gnt_o(d_r_gnt), .reader_addr_i(r_addr),
    .reader_we_i(r_we), .reader_be_i(r_be), .reader_wdata_i(r_wdata),
    .reader_rvalid_o(d_r_rvalid), .reader_rdata_o(d_r_rdata), .irq_o(d_irq)
  );

  obi_fifo_mailbox #(.Depth(8), .NumQueues(2), .BlockOnFull(1'b0)) dut_drop (
    .clk_i(clk), .rst_ni(rst_n),
    .writer_req_i(w_req), .writer_gnt_o(x_w_gnt), .writer_addr_i(w_addr),
    .writer_we_i(w_we), .writer_be_i(w_be), .writer_wdata_i(w_wdata),
    .writer_rvalid_o(x_w_rvalid), .writer_rdata_o(x_w_rdata),
    .reader_req_i(r_req), .reader_gnt_o(x_r_gnt), .reader_addr_i(r_addr),
    .reader_we_i(r_we), .reader_be_i(r_be), .reader_wdata_i(r_wdata),
    .reader_rvalid_o(x_r_rvalid), .reader_rdata_o(x_r_rdata), .irq_o(x_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wa(input int q);
    return 32'(q) << 2;
  endfunction

  function automatic logic [31:0] ra(input int q, input reg_sel_e s);
    return (32'(q) << 4) | (32'(s) << 2);
  endfunction

  // Reader responses: one expected record per request, consumed in order.
  always @(negedge clk) begin
    if (rst_n && d_r_rvalid) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 32'(sb.size()), 32'd1);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check(e.name, d_r_rdata, e.exp);
        check({e.name, "_drop"}, x_r_rdata, e.exp2);
        check("drop_rvalid", 32'(x_r_rvalid), 32'd1);
      end
    end
  end

  task automatic rd(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                    input string name, input logic [31:0] exp, input logic [31:0] exp2);
    r_req = 1'b1; r_addr = addr; r_we = we; r_wdata = wdata;
    sb.push_back('{name: name, exp: exp, exp2: exp2});
    @(posedge clk); #1;
    r_req = 1'b0; r_we = 1'b0;
  endtask

  task automatic rd_reg(input int q, input reg_sel_e s, input string name, input logic [31:0] exp);
    rd(ra(q, s), 1'b0, 32'h0, name, exp, exp);
  endtask

  task automatic wr_reg(input int q, input reg_sel_e s, input logic [31:0] data);
    rd(ra(q, s), 1'b1, data, "reg_write_rdata", 32'h0, 32'h0);
  endtask

  // Writer push on the blocking instance; waits a bounded number of cycles for gnt.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bit granted;
    granted = 1'b0;
    w_req = 1'b1; w_we = 1'b1; w_addr = addr; w_wdata = data;
    for (int i = 0; i < 20; i++) begin
      if (d_w_gnt) begin
        granted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (granted) begin
      @(posedge clk); #1;
    end
    w_req = 1'b0; w_we = 1'b0;
    if (!granted) begin
      check("wr_grant_timeout", 32'(granted), 32'd1);
    end else begin
      check("wr_rvalid", 32'(d_w_rvalid), 32'd1);
      check("wr_rdata", d_w_rdata, 32'h0);
    end
  endtask

  task automatic add(input vkind_e k, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string n);
    vecs.push_back('{kind: k, addr: a, data: d, exp: e, name: n});
  endtask

  initial begin
    w_req = 0; w_we = 0; w_addr = 0; w_wdata = 0; w_be = 4'hF;
    r_req = 0; r_we = 0; r_addr = 0; r_wdata = 0; r_be = 4'hF;
    rst_n = 1'b0;

    // Fill/drain, underflow, THRESH width and CTRL readback.
    for (int i = 0; i < 8; i++) add(V_PUSH, wa(0), 32'hA0 + 32'(i), 32'h0, "fill_push");
    add(V_READ, ra(0, RegStatus), 0, 32'h0002_0008, "fill_status_full");
    for (int i = 0; i < 8; i++) add(V_READ, ra(0, RegData), 0, 32'hA0 + 32'(i), "drain_data");
    add(V_READ,  ra(0, RegStatus), 0,     32'h0001_0000, "drain_status_empty");
    add(V_READ,  ra(1, RegData),   0,     32'h0,         "udf_data");
    add(V_READ,  ra(1, RegStatus), 0,     32'h0009_0000, "udf_status");
    add(V_WRITE, ra(1, RegCtrl),   32'h2, 32'h0,         "udf_clear");
    add(V_READ,  ra(1, RegStatus), 0,     32'h0001_0000, "udf_cleared");
    add(V_WRITE, ra(1, RegThresh), 32'h1F, 32'h0,        "thresh_wr");
    add(V_READ,  ra(1, RegThresh), 0,     32'h0000_000F, "thresh_width");
    add(V_WRITE, ra(1, RegThresh), 32'h0, 32'h0,         "thresh_zero");
    add(V_READ,  ra(1, RegCtrl),   0,     32'h0,         "ctrl_reads_zero");

    #12;
    check("rst_irq", 32'(d_irq), 32'h0);
    check("rst_rd_rvalid", 32'(d_r_rvalid), 32'h0);
    check("rst_rd_rdata", d_r_rdata, 32'h0);
    check("rst_wr_rvalid", 32'(d_w_rvalid), 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reader_gnt", 32'(d_r_gnt), 32'h1);
    rd_reg(0, RegStatus, "rst_status_q0", 32'h0001_0000);
    rd_reg(1, RegStatus, "rst_status_q1", 32'h0001_0000);

    foreach (vecs[i]) begin
      unique case (vecs[i].kind)
        V_PUSH:  wr(vecs[i].addr, vecs[i].data);
        V_READ:  rd(vecs[i].addr, 1'b0, 32'h0, vecs[i].name, vecs[i].exp, vecs[i].exp);
        default: rd(vecs[i].addr, 1'b1, vecs[i].data, vecs[i].name, 32'h0, 32'h0);
      endcase
    end

    // Ninth write: blocked on one instance, dropped with ovf on the other.
    for (int i = 0; i < 8; i++) wr(wa(0), 32'hA0 + 32'(i));
    w_req = 1'b1; w_we = 1'b1; w_addr = wa(0); w_wdata = 32'hB8;
    check("ovf_block_gnt0", 32'(d_w_gnt), 32'h0);
    check("ovf_drop_gnt1", 32'(x_w_gnt), 32'h1);
    @(posedge clk); #1;
    check("ovf_block_gnt_held", 32'(d_w_gnt), 32'h0);
    check("ovf_block_no_rvalid", 32'(d_w_rvalid), 32'h0);
    check("ovf_drop_rvalid", 32'(x_w_rvalid), 32'h1);
    rd_reg(0, RegData, "ovf_pop", 32'hA0);
    check("ovf_block_gnt_after_pop", 32'(d_w_gnt), 32'h1);
    @(posedge clk); #1;
    w_req = 1'b0; w_we = 1'b0;
    check("ovf_block_rvalid", 32'(d_w_rvalid), 32'h1);
    rd(ra(0, RegStatus), 1'b0, 32'h0, "ovf_status", 32'h0002_0008, 32'h0006_0008);
    wr_reg(0, RegCtrl, 32'h2);
    rd_reg(0, RegStatus, "ovf_cleared", 32'h0002_0008);
    wr_reg(0, RegCtrl, 32'h1);
    rd_reg(0, RegStatus, "flush_status", 32'h0001_0000);

    // Push and pop together on a level-3 queue.
    for (int i = 0; i < 3; i++) wr(wa(0), 32'hC0 + 32'(i));
    w_req = 1'b1; w_we = 1'b1; w_addr = wa(0); w_wdata = 32'hC3;
    rd_reg(0, RegData, "simul_pop_old_head", 32'hC0);
    w_req = 1'b0; w_we = 1'b0;
    check("simul_push_rvalid", 32'(d_w_rvalid), 32'h1);
    rd_reg(0, RegStatus, "simul_level3", 32'h0000_0003);
    for (int i = 1; i < 4; i++) rd_reg(0, RegData, "simul_drain", 32'hC0 + 32'(i));
    rd_reg(0, RegStatus, "simul_empty", 32'h0001_0000);

    // Push and pop together on an empty queue: no fall-through.
    w_req = 1'b1; w_we = 1'b1; w_addr = wa(0); w_wdata = 32'hD0;
    rd_reg(0, RegData, "empty_simul_pop", 32'h0);
    w_req = 1'b0; w_we = 1'b0;
    rd_reg(0, RegStatus, "empty_simul_status", 32'h0008_0001);
    wr_reg(0, RegCtrl, 32'h2);
    rd_reg(0, RegData, "empty_simul_data", 32'hD0);
    rd_reg(0, RegStatus, "empty_simul_done", 32'h0001_0000);

    // Threshold interrupt.
    wr_reg(0, RegThresh, 32'h4);
    for (int i = 0; i < 4; i++) wr(wa(0), 32'hE0 + 32'(i));
    check("irq_lags_push", 32'(d_irq), 32'h0);
    @(posedge clk); #1;
    check("irq_set", 32'(d_irq), 32'h1);
    rd_reg(0, RegStatus, "irq_status", 32'h0010_0004);
    rd_reg(0, RegData, "irq_pop", 32'hE0);
    check("irq_lags_pop", 32'(d_irq), 32'h1);
    @(posedge clk); #1;
    check("irq_clear", 32'(d_irq), 32'h0);
    wr_reg(0, RegThresh, 32'h0);
    for (int i = 0; i < 5; i++) wr(wa(0), 32'hE4 + 32'(i));
    repeat (2) @(posedge clk);
    #1;
    check("irq_thresh0_full", 32'(d_irq), 32'h0);
    wr_reg(0, RegCtrl, 32'h1);

    // Flush concurrent with a push.
    wr(wa(0), 32'hF0);
    wr(wa(0), 32'hF1);
    w_req = 1'b1; w_we = 1'b1; w_addr = wa(0); w_wdata = 32'hF2;
    wr_reg(0, RegCtrl, 32'h1);
    w_req = 1'b0; w_we = 1'b0;
    rd_reg(0, RegStatus, "flush_push_status", 32'h0001_0000);

    // Stalled writer is granted the cycle after a flush.
    for (int i = 0; i < 8; i++) wr(wa(0), 32'h100 + 32'(i));
    w_req = 1'b1; w_we = 1'b1; w_addr = wa(0); w_wdata = 32'h1FF;
    check("stall_gnt0", 32'(d_w_gnt), 32'h0);
    wr_reg(0, RegCtrl, 32'h1);
    check("stall_gnt_after_flush", 32'(d_w_gnt), 32'h1);
    @(posedge clk); #1;
    w_req = 1'b0; w_we = 1'b0;
    rd(ra(0, RegStatus), 1'b0, 32'h0, "stall_status", 32'h0000_0001, 32'h0004_0001);
    rd_reg(0, RegData, "stall_data", 32'h1FF);
    wr_reg(0, RegCtrl, 32'h3);

    // Queue independence.
    wr(wa(0), 32'h55);
    wr(wa(1), 32'h11);
    wr(wa(1), 32'h22);
    rd_reg(1, RegData, "indep_q1_a", 32'h11);
    rd_reg(0, RegStatus, "indep_q0_level", 32'h0000_0001);
    rd_reg(1, RegData, "indep_q1_b", 32'h22);
    rd_reg(0, RegData, "indep_q0_data", 32'h55);
    rd_reg(1, RegStatus, "indep_q1_empty", 32'h0001_0000);

    // Asynchronous reset in the middle of traffic.
    wr_reg(0, RegThresh, 32'h1);
    wr(wa(0), 32'h77);
    wr(wa(0), 32'h78);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_irq", 32'(d_irq), 32'h1);
    w_req = 1'b1; w_we = 1'b1; w_addr = wa(0); w_wdata = 32'h79;
    r_req = 1'b1; r_we = 1'b0; r_addr = ra(0, RegData);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_irq", 32'(d_irq), 32'h0);
    check("async_rst_rd_rvalid", 32'(d_r_rvalid), 32'h0);
    check("async_rst_wr_rvalid", 32'(d_w_rvalid), 32'h0);
    w_req = 1'b0; w_we = 1'b0; r_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_reg(0, RegStatus, "post_rst_q0", 32'h0001_0000);
    rd_reg(1, RegStatus, "post_rst_q1", 32'h0001_0000);
    rd_reg(0, RegThresh, "post_rst_thresh", 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%08h, expected 0x%08h", 32'(n_checks), 32'h0);
    $fatal(1, "timeout");
  end

endmodule
